// File: rtl/serial_word_deserializer_if.sv
// Handshake bundle between the serial source, the deserializer and the FIR core:
// a serial bit stream in and a parallel word stream out.
interface serial_word_deserializer_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  i_din;
  logic                  i_din_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_word;
  logic                  o_word_valid;
  logic                  i_word_ready;

  modport slave (
    input  i_din, i_din_valid, i_word_ready,
    output o_ready, o_word, o_word_valid
  );

  modport master (
    output i_din, i_din_valid, i_word_ready,
    input  o_ready, o_word, o_word_valid
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// LSB-first serial-to-parallel word assembler with a small output FIFO.
// An interrupted frame is discarded and flagged with a one-cycle error pulse.
module serial_word_deserializer #(
  parameter  int DATA_WIDTH = 24,
  parameter  int FIFO_DEPTH = 2,
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1),
  localparam int IDX_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  serial_word_deserializer_if.slave    bus,
  output logic                         o_frame_err,
  output logic [CNT_W-1:0]             o_bit_cnt
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  err_q;
  logic [IDX_W:0]        wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] last_word_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  fifo_full, fifo_empty;
  logic                  accept, push, pop, abort;
  logic [DATA_WIDTH-1:0] shifted;

  // Wrap bits differ with equal indices -> full; fully equal -> empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                      (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  assign bus.o_ready      = i_rst_n & i_en & ~fifo_full;
  assign bus.o_word_valid = ~fifo_empty;
  assign bus.o_word       = fifo_empty ? last_word_q : mem_q[rd_ptr_q[IDX_W-1:0]];
  assign o_frame_err      = err_q;
  assign o_bit_cnt        = cnt_q;

  assign accept  = i_en & bus.i_din_valid & bus.o_ready;
  assign pop     = i_en & ~fifo_empty & bus.i_word_ready;
  assign shifted = {bus.i_din, shreg_q[DATA_WIDTH-1:1]};

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = shifted;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_d = shifted;
          if (cnt_q == LAST_CNT) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (i_en && !bus.i_din_valid) begin
          abort   = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_word_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      err_q    <= abort;
      wr_ptr_q <= wr_ptr_q + (IDX_W+1)'(push);
      rd_ptr_q <= rd_ptr_q + (IDX_W+1)'(pop);
      // Remember the departing head so o_word holds once the FIFO drains.
      if (pop) last_word_q <= mem_q[rd_ptr_q[IDX_W-1:0]];
    end
  end

  // NOTE: FIFO storage is not reset; the empty flag masks stale entries and
  // o_word falls back to last_word_q, which is reset.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= shifted;
  end

endmodule
